// File: rtl/misr_signature_checker.sv
// misr_signature_checker
// Response compactor: folds valid response words into a multiple-input
// signature register over a programmed number of patterns. It then compares
// the final signature against a golden value and reports done/pass.
// Optional build macro MISR_XMASK_EN adds a per-bit response mask input.
// A mask bit of 1 forces that response lane to zero before it is folded in.
module misr_signature_checker #(
    parameter int               WIDTH = 5,
    parameter int               CNT_W = 8,
    parameter logic [WIDTH-1:0] POLY  = 5'b00101,
    parameter logic [WIDTH-1:0] SEED  = 5'b00001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [WIDTH-1:0] golden_sig,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_in,
`ifdef MISR_XMASK_EN
    input  logic [WIDTH-1:0] resp_mask,
`endif
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPACT = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sig;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_num;
    logic [WIDTH-1:0] r_golden;
    logic             r_pass;
    logic             w_start;
    logic             w_beat;
    logic             w_last;
    logic [WIDTH-1:0] w_word;

    // One MISR step.
    // The register shifts toward the MSB. When the MSB is set before the
    // shift, the feedback taps are XORed in. The response word is then
    // XORed across all bits.
    function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] sig,
                                                   input logic [WIDTH-1:0] word);
        logic [WIDTH-1:0] fb;
        fb = sig[WIDTH-1] ? POLY : '0;
        return {sig[WIDTH-2:0], 1'b0} ^ fb ^ word;
    endfunction

`ifdef MISR_XMASK_EN
    assign w_word = resp_in & ~resp_mask;
`else
    assign w_word = resp_in;
`endif

    assign w_start = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_beat  = resp_valid && (r_state == S_COMPACT);
    assign w_last  = (r_count == (r_num - ONE));

    // State register; reset abandons any run in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and status outputs
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                done = (r_state == S_DONE);
                if (start) begin
                    w_next = (num_patterns == '0) ? S_COMPARE : S_COMPACT;
                end
            end
            S_COMPACT: begin
                busy = 1'b1;
                if (resp_valid && w_last) begin
                    w_next = S_COMPARE;
                end
            end
            S_COMPARE: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Run setup on start, signature folding on valid beats, final compare
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sig    <= SEED;
            r_count  <= '0;
            r_num    <= '0;
            r_golden <= '0;
            r_pass   <= 1'b0;
        end else if (w_start) begin
            r_num    <= num_patterns;
            r_golden <= golden_sig;
            r_sig    <= SEED;
            r_count  <= '0;
            r_pass   <= 1'b0;
        end else if (w_beat) begin
            r_sig   <= misr_step(r_sig, w_word);
            r_count <= r_count + ONE;
        end else if (r_state == S_COMPARE) begin
            r_pass <= (r_sig == r_golden);
        end
    end

    assign signature = r_sig;
    assign count     = r_count;
    assign pass      = r_pass;

endmodule

// File: tb/tb_misr_signature_checker.sv
// tb_misr_signature_checker
// Directed scenarios with literal expectations, then randomized compaction
// runs. A polynomial-arithmetic reference model tracks the expected outputs
// and a compare process checks them on every falling clock edge.
// Optional build macro MISR_XMASK_EN enables the response-mask scenarios.
module tb_misr_signature_checker;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] num_patterns;
    logic [4:0] golden_sig;
    logic       resp_valid;
    logic [4:0] resp_in;
`ifdef MISR_XMASK_EN
    logic [4:0] resp_mask;
`endif
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] signature;
    logic [7:0] count;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    misr_signature_checker dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .num_patterns(num_patterns),
        .golden_sig(golden_sig),
        .resp_valid(resp_valid),
        .resp_in(resp_in),
`ifdef MISR_XMASK_EN
        .resp_mask(resp_mask),
`endif
        .busy(busy),
        .done(done),
        .pass(pass),
        .signature(signature),
        .count(count)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // The signature is multiplied by x modulo x^5+x^2+1, then the word is added.
    function automatic logic [4:0] fold(input logic [4:0] s, input logic [4:0] w);
        logic [5:0] t;
        t = {s, 1'b0};
        if (t[5]) t = t ^ 6'b100101;
        return t[4:0] ^ w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model.
    // m_left is the number of beats still owed. m_cmp marks the single
    // compare cycle. m_done marks the reported result.
    logic [4:0] m_sig = 5'h01;
    logic [4:0] m_gold = 0;
    int         m_cnt = 0;
    int         m_left = 0;
    bit         m_cmp = 0;
    bit         m_done = 0;
    bit         m_pass = 0;

    task automatic model_step();
        logic [4:0] w;
        if (reset) begin
            m_sig = 5'h01; m_gold = 0; m_cnt = 0; m_left = 0;
            m_cmp = 0; m_done = 0; m_pass = 0;
        end else if (m_cmp) begin
            m_pass = (m_sig == m_gold);
            m_cmp = 0;
            m_done = 1;
        end else if (m_left == 0 && start) begin
            m_gold = golden_sig; m_sig = 5'h01; m_cnt = 0;
            m_pass = 0; m_done = 0;
            m_left = int'(num_patterns);
            m_cmp = (num_patterns == 0);
        end else if (m_left > 0 && resp_valid) begin
            w = resp_in;
`ifdef MISR_XMASK_EN
            w = w & ~resp_mask;
`endif
            m_sig = fold(m_sig, w);
            m_cnt++;
            m_left--;
            if (m_left == 0) m_cmp = 1;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("sig", signature, m_sig);
            chk("count", count, m_cnt);
            chk("busy", busy, (m_left > 0) || m_cmp);
            chk("done", done, m_done);
            if (m_done) chk("pass", pass, m_pass);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [7:0] n, input logic [4:0] g);
        num_patterns = n;
        golden_sig = g;
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic beat(input logic [4:0] w);
        resp_valid = 1;
        resp_in = w;
        tick();
        resp_valid = 0;
    endtask

    task automatic wait_done(input string nm);
        int i;
        for (i = 0; i < 600; i++) begin
            if (done) break;
            tick();
        end
        if (i == 600) chk({nm, "_timeout"}, 0, 1);
    endtask

    initial begin
        reset = 1; start = 0; num_patterns = 0; golden_sig = 0;
        resp_valid = 0; resp_in = 0;
`ifdef MISR_XMASK_EN
        resp_mask = 0;
`endif
        tick(); tick();
        chk_en = 1;
        chk("rst_sig", signature, 5'h01);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        reset = 0;
        tick();

        // The expected values below were computed by hand.
        chk("model_a", fold(5'h01, 5'h00), 5'h02);
        chk("model_b", fold(5'h01, 5'h1F), 5'h1D);
        chk("model_c", fold(5'h1D, 5'h1F), 5'h00);

        // Single beat
        start_run(1, 5'h02);
        beat(5'h00);
        chk("t1_sig", signature, 5'h02);
        chk("t1_cmpbusy", busy, 1);
        tick();
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        chk("t1_count", count, 1);

        // Two beats, matching golden
        start_run(2, 5'h00);
        chk("t2_doneclr", done, 0);
        beat(5'h1F);
        chk("t2_sig1", signature, 5'h1D);
        beat(5'h1F);
        chk("t2_sig2", signature, 5'h00);
        tick();
        chk("t2_done", done, 1);
        chk("t2_pass", pass, 1);

        // Two beats with a gap, wrong golden
        start_run(2, 5'h01);
        beat(5'h1F);
        repeat (3) begin
            tick();
            chk("t3_gapcount", count, 1);
            chk("t3_gapsig", signature, 5'h1D);
        end
        beat(5'h1F);
        tick();
        chk("t3_done", done, 1);
        chk("t3_pass", pass, 0);
        chk("t3_sig", signature, 5'h00);

        // Zero-length run
        start_run(0, 5'h01);
        chk("t4_busy", busy, 1);
        tick();
        chk("t4_done", done, 1);
        chk("t4_pass", pass, 1);
        chk("t4_sig", signature, 5'h01);

        // Reset mid-run
        start_run(4, 5'h00);
        beat(5'h03);
        reset = 1;
        tick();
        reset = 0;
        chk("t5_sig", signature, 5'h01);
        chk("t5_count", count, 0);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);

        // Start while busy is ignored
        start_run(4, 5'h00);
        beat(5'h03);
        num_patterns = 1;
        start = 1;
        tick();
        start = 0;
        chk("t6_count", count, 1);
        chk("t6_busy", busy, 1);
        beat(5'h01); beat(5'h02); beat(5'h04);
        tick();
        chk("t6_done", done, 1);
        chk("t6_count4", count, 4);

`ifdef MISR_XMASK_EN
        // A fully masked word contributes nothing to the signature.
        resp_mask = 5'h1F;
        start_run(1, 5'h02);
        beat(5'h1F);
        tick();
        chk("tm_sig", signature, 5'h02);
        chk("tm_pass", pass, 1);
        resp_mask = 0;
`endif

        // Randomized runs
        for (int r = 0; r < 40; r++) begin
            logic [7:0] n;
            logic [4:0] words[$];
            logic [4:0] pred;
            logic [4:0] g;
            n = ($urandom_range(0, 14) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
            words.delete();
            pred = 5'h01;
            for (int k = 0; k < int'(n); k++) begin
                words.push_back(5'($urandom_range(0, 31)));
            end
`ifdef MISR_XMASK_EN
            resp_mask = 5'($urandom_range(0, 31));
            foreach (words[k]) pred = fold(pred, words[k] & ~resp_mask);
`else
            foreach (words[k]) pred = fold(pred, words[k]);
`endif
            g = $urandom_range(0, 1) ? pred : 5'($urandom_range(0, 31));
            start_run(n, g);
            foreach (words[k]) begin
                int gap;
                gap = $urandom_range(0, 3);
                for (int j = 0; j < gap; j++) begin
                    start = ($urandom_range(0, 3) == 0);
                    num_patterns = 8'($urandom_range(0, 255));
                    tick();
                    start = 0;
                end
                beat(words[k]);
            end
            resp_valid = $urandom_range(0, 1);
            resp_in = 5'($urandom_range(0, 31));
            wait_done("rnd");
            resp_valid = 0;
            chk("rnd_pass", pass, (pred == g));
            chk("rnd_sig", signature, pred);
            chk("rnd_count", count, n);
            tick();
        end

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
